// File: rtl/nexys_keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, full-map debounce, single-press events
// and an 8-digit hex entry buffer that feeds the 7-segment display driver.
module nexys_keypad_scanner #(
   parameter int unsigned PRESCALE       = 100,
   parameter int unsigned COL_TICKS      = 250,
   parameter int unsigned DEBOUNCE_SCANS = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [3:0]  ROW,
   input  logic        CLR,
   output logic [3:0]  COL,
   output logic [15:0] KEY_MAP,
   output logic        KEY_DOWN,
   output logic        MULTI,
   output logic [3:0]  KEY_CODE,
   output logic        KEY_VALID,
   output logic [31:0] HEX_OUT,
   output logic [7:0]  DIGIT_EN
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned DW = $clog2(COL_TICKS);
   localparam int unsigned BW = $clog2(DEBOUNCE_SCANS);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] DW_LAST  = DW'(COL_TICKS - 1);
   localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_SCANS - 1);
   // Nibble i holds the key legend for map bit i (column*4 + row).
   localparam logic [63:0] CODE_LUT = 64'hDCBA_E963_F852_0741;

   logic          run_q, run_d;
   logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    ci_q, ci_d;
   logic [15:0]   snap_q, snap_d, prev_q, prev_d;
   logic [BW-1:0] dbcnt_q, dbcnt_d;
   logic [15:0]   key_map_q, key_map_d, km_dly_q, km_dly_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic [31:0]   hex_q, hex_d;
   logic [7:0]    den_q, den_d;
   logic          tick, scan_done, fire;
   logic [3:0]    code;

   function automatic logic [3:0] code_of(input logic [15:0] map);
      logic [3:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (map[i]) idx = 4'(i);
      end
      return CODE_LUT[{idx, 2'b00} +: 4];
   endfunction

   always_comb begin
      run_d       = 1'b1;
      row_s1_d    = ROW;
      row_s2_d    = row_s1_q;
      pre_d       = pre_q;
      dwell_d     = dwell_q;
      ci_d        = ci_q;
      snap_d      = snap_q;
      prev_d      = prev_q;
      dbcnt_d     = dbcnt_q;
      key_map_d   = key_map_q;
      km_dly_d    = key_map_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      hex_d       = hex_q;
      den_d       = den_q;
      scan_done   = 1'b0;

      tick = run_q && (pre_q == PRE_LAST);
      if (run_q) pre_d = tick ? '0 : pre_q + PW'(1);

      if (tick) begin
         if (dwell_q == DW_LAST) begin
            dwell_d = '0;
            ci_d    = ci_q + 2'd1;
            for (int unsigned r = 0; r < 4; r++) begin
               snap_d[{ci_q, r[1:0]}] = ~row_s2_q[r];
            end
            scan_done = (ci_q == 2'd3);
         end else begin
            dwell_d = dwell_q + DW'(1);
         end
      end

      // Debounce compares the freshly completed snapshot, column 3 included.
      if (scan_done) begin
         prev_d = snap_d;
         if (snap_d == prev_q) dbcnt_d = (dbcnt_q == DB_LAST) ? DB_LAST : dbcnt_q + BW'(1);
         else                  dbcnt_d = '0;
         if ((dbcnt_d == DB_LAST) && (snap_d != key_map_q)) key_map_d = snap_d;
      end

      // Event only on a 0 -> single-key transition, seen one cycle after the map update.
      fire = (km_dly_q == '0) && (key_map_q != '0) &&
             ((key_map_q & (key_map_q - 16'd1)) == '0);
      code = code_of(key_map_q);
      if (fire) begin
         key_valid_d = 1'b1;
         key_code_d  = code;
         hex_d       = CLR ? {28'h0, code} : {hex_q[27:0], code};
         den_d       = CLR ? 8'h01 : {den_q[6:0], 1'b1};
      end else if (CLR) begin
         hex_d = '0;
         den_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         run_q       <= 1'b0;
         row_s1_q    <= '1;
         row_s2_q    <= '1;
         pre_q       <= '0;
         dwell_q     <= '0;
         ci_q        <= '0;
         snap_q      <= '0;
         prev_q      <= '0;
         dbcnt_q     <= '0;
         key_map_q   <= '0;
         km_dly_q    <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         hex_q       <= '0;
         den_q       <= '0;
      end else begin
         run_q       <= run_d;
         row_s1_q    <= row_s1_d;
         row_s2_q    <= row_s2_d;
         pre_q       <= pre_d;
         dwell_q     <= dwell_d;
         ci_q        <= ci_d;
         snap_q      <= snap_d;
         prev_q      <= prev_d;
         dbcnt_q     <= dbcnt_d;
         key_map_q   <= key_map_d;
         km_dly_q    <= km_dly_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         hex_q       <= hex_d;
         den_q       <= den_d;
      end
   end

   assign COL       = run_q ? ~(4'b0001 << ci_q) : 4'b1111;
   assign KEY_MAP   = key_map_q;
   assign KEY_DOWN  = |key_map_q;
   assign MULTI     = (key_map_q & (key_map_q - 16'd1)) != '0;
   assign KEY_CODE  = key_code_q;
   assign KEY_VALID = key_valid_q;
   assign HEX_OUT   = hex_q;
   assign DIGIT_EN  = den_q;

endmodule
